sync_down_counter: RTL
======================

SYNC_DOWN_COUNTER -- requirements
Module: sync_down_counter

Interface
REQ-001 Parameter: WIDTH, default 4, counter width in bits (legal range 2..16).
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge only; no derived or ripple clocks.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: load  input  1  start request; captures load_val and begins counting.
REQ-005 Port: load_val  input  WIDTH  start value for the count.
REQ-006 Port: en  input  1  count enable; when 0 in RUN, the count holds.
REQ-007 Port: auto_reload  input  1  1 = reload load_val at terminal count; 0 = one-shot.
REQ-008 Port: abort  input  1  stop the count and return to IDLE.
REQ-009 Port: count  output  WIDTH  current count value.
REQ-010 Port: busy  output  1  high while in RUN.
REQ-011 Port: tc  output  1  one-cycle terminal-count pulse.
REQ-012 Port: done  output  1  level; high in DONE state.

Function
REQ-013 FSM states SHALL be IDLE, RUN and DONE, fully synchronous to clk.
REQ-014 IDLE: load=1 -> count<=load_val, go to RUN; otherwise hold count.
REQ-015 RUN with en=1 and count!=0 -> count<=count-1 each cycle.
REQ-016 RUN with en=0 -> count held; state held.
REQ-017 RUN with en=1 and count==0 -> tc=1 for that cycle (registered, visible the following cycle).
REQ-018 At that terminal cycle, auto_reload=1 -> count<=reload register and stay in RUN; auto_reload=0 -> go to DONE with count at 0.
REQ-019 The reload register SHALL capture load_val on every accepted load; later load_val changes SHALL not affect the reload value.
REQ-020 load_val=0 SHALL give tc on the first enabled RUN cycle (period 1 cycle); load_val=N SHALL give a tc period of N+1 enabled cycles.
REQ-021 DONE: done=1 and count=0; load=1 -> restart as in IDLE; otherwise stay in DONE.
REQ-022 load=1 in RUN -> restart: count<=load_val, reload register updated, tc suppressed that cycle.
REQ-023 abort=1 in any state -> go to IDLE next cycle with count=0 and no tc; abort has priority over load, en and terminal count.
REQ-024 Priority order SHALL be abort > load > terminal count > decrement.
REQ-025 busy SHALL be 1 in RUN only; done SHALL be 1 in DONE only; they are never 1 together.
REQ-026 Arithmetic SHALL be modulo 2^WIDTH, with no underflow past 0 (terminal count intercepts 0).
REQ-027 All outputs SHALL be registered (glitch-free).

Reset
REQ-028 rst=1 SHALL immediately, without waiting for clk, force state=IDLE, count=0, reload register=0, tc=0, busy=0, done=0.
REQ-029 Reset asserted mid-count SHALL discard the count; after release the block SHALL wait in IDLE for load.
REQ-030 The first rising edge after rst deasserts SHALL be a normal functional edge.

Verification
REQ-031 One-shot: WIDTH=4, load_val=3, auto_reload=0, en=1 -> count 3,2,1,0; tc pulses once; done=1 and busy=0 thereafter.
REQ-032 Auto-reload: load_val=2, auto_reload=1, en=1 for 9 cycles -> count 2,1,0,2,1,0,2,1,0; tc every 3rd cycle; busy stays 1.
REQ-033 Enable gaps: load_val=5, en toggled 1,0,0,1 -> count 5,4,4,4,3; no tc.
REQ-034 Restart and abort: load 9, two cycles later load 4 -> count 4 with no tc; then abort together with load=1 -> IDLE, count=0, tc=0.
REQ-035 Async reset: assert rst between clk edges with count=6 -> count=0 and busy=0 before the next edge; after release the block stays in IDLE until load.
REQ-036 Boundary: load_val=0 with auto_reload=1 -> tc every cycle and count constant 0; load_val=15 (WIDTH=4) -> tc period of 16 cycles, with no wrap to 15 except by reload.

Source files
------------

// File: rtl/sync_down_counter_if.sv
// Port bundle for sync_down_counter. The master side drives the controls and
// the slave side (the counter) drives the count and status.
interface sync_down_counter_if #(
  parameter int WIDTH = 4
);
  // There is no valid/ready pair here. load and abort are single-cycle
  // requests that are sampled on every rising clk edge and never stall.
  // count, busy, tc, done and state_dbg are registered outputs of the counter.
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             auto_reload;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tc;
  logic             done;
  logic [1:0]       state_dbg;

  modport master (
    output load, load_val, en, auto_reload, abort,
    input  count, busy, tc, done, state_dbg
  );

  modport slave (
    input  load, load_val, en, auto_reload, abort,
    output count, busy, tc, done, state_dbg
  );
endinterface

// File: rtl/sync_down_counter.sv
// Loadable down counter with a one-shot or auto-reload mode.
// All outputs come straight from flops.
module sync_down_counter #(
  parameter int WIDTH = 4
) (
  input logic            clk,
  input logic            rst,
  sync_down_counter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             busy_q, done_q;

  // The priority chain is abort, then load, then terminal count, then
  // decrement. Terminal count intercepts zero, so the count never wraps.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (bus.abort) begin
      state_d = IDLE;
      count_d = '0;
    end else if (bus.load) begin
      state_d  = RUN;
      count_d  = bus.load_val;
      reload_d = bus.load_val;
    end else if (state_q == RUN && bus.en) begin
      if (count_q == '0) begin
        tc_d = 1'b1;
        if (bus.auto_reload) begin
          count_d = reload_q;
        end else begin
          count_d = '0;
          state_d = DONE;
        end
      end else begin
        count_d = count_q - ONE;
      end
    end
  end

  // busy and done are registered from the next state, not decoded from the
  // state register, so they cannot glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      busy_q   <= (state_d == RUN);
      done_q   <= (state_d == DONE);
    end
  end

  assign bus.count     = count_q;
  assign bus.tc        = tc_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.state_dbg = state_q;

endmodule
